// File: rtl/controle_senha.sv
// controle_senha: access-code controller for the digital safe.
//
// Collects BCD keypad digits into a buffer, then checks them against the
// stored code one digit per clock through one shared comparador instance.
// Also tracks the open/closed state, counts consecutive failed attempts,
// enforces a timed lockout and lets the code be changed while open.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   digito        keypad digit (BCD)
//   digito_valido one-cycle strobe qualifying digito
//   confirmar     one-cycle strobe: submit entry / close safe
//   modo_troca    one-cycle strobe: request code change (only while open)
//   aberto        safe unlocked (level)
//   bloqueado     lockout active (level)
//   erro          one-cycle pulse on rejected entry
//   troca_ok      one-cycle pulse when a new code is stored
//   qtd_digitos   digits currently buffered
//   tentativas    consecutive failed attempts so far
//
// Handshake: every input is a single-cycle strobe sampled on the rising
// edge; there is no back-pressure. Strobes that arrive in a state that does
// not use them (VERIFICA, BLOQUEIO, ...) are dropped, not queued.

// 4-bit equality comparator shared by the verification sequence.
module comparador (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       aeqb
);
  assign aeqb = (a == b);
endmodule

module controle_senha #(
  parameter int NUM_DIGITOS    = 4,
  parameter int MAX_TENTATIVAS = 3,
  parameter int TEMPO_BLOQUEIO = 16,
  parameter logic [4*NUM_DIGITOS-1:0] SENHA_PADRAO = 16'h1234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digito,
  input  logic       digito_valido,
  input  logic       confirmar,
  input  logic       modo_troca,
  output logic       aberto,
  output logic       bloqueado,
  output logic       erro,
  output logic       troca_ok,
  output logic [3:0] qtd_digitos,
  output logic [1:0] tentativas
);

  localparam int IDX_W = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
  localparam int TMR_W = (TEMPO_BLOQUEIO > 1) ? $clog2(TEMPO_BLOQUEIO) : 1;
  localparam logic [3:0]       NUM_D    = 4'(NUM_DIGITOS);
  localparam logic [1:0]       MAX_T    = 2'(MAX_TENTATIVAS);
  localparam logic [IDX_W-1:0] ULT_IDX  = IDX_W'(NUM_DIGITOS - 1);
  localparam logic [TMR_W-1:0] CARGA_TM = TMR_W'(TEMPO_BLOQUEIO - 1);

  typedef enum logic [2:0] {
    OCIOSO, ENTRADA, VERIFICA, ABERTO, TROCA, BLOQUEIO
  } estado_t;

  estado_t          estado, estadoProx;
  logic [3:0]       bufDig  [NUM_DIGITOS];
  logic [3:0]       bufProx [NUM_DIGITOS];
  logic [3:0]       codigo  [NUM_DIGITOS];
  logic [3:0]       codProx [NUM_DIGITOS];
  logic [3:0]       qtd, qtdProx;
  logic [IDX_W-1:0] idx, idxProx;
  logic             falhaVer, falhaProx;
  logic [1:0]       tent, tentProx;
  logic [TMR_W-1:0] timer, timerProx;
  logic             erroR, erroProx;
  logic             trocaR, trocaProx;
  logic             limpar, falhou, digitoAceito;
  logic             aeqb;

  // Verification always walks all digits; only the sticky flag remembers a
  // mismatch, so latency is independent of where the wrong digit sits.
  comparador uComparador (
    .a    (bufDig[idx]),
    .b    (codigo[idx]),
    .aeqb (aeqb)
  );

  assign digitoAceito = digito_valido && (digito <= 4'd9) && (qtd < NUM_D);

  always_comb begin
    estadoProx = estado;
    bufProx    = bufDig;
    codProx    = codigo;
    qtdProx    = qtd;
    idxProx    = idx;
    falhaProx  = falhaVer;
    tentProx   = tent;
    timerProx  = timer;
    erroProx   = 1'b0;
    trocaProx  = 1'b0;
    limpar     = 1'b0;
    falhou     = 1'b0;

    case (estado)
      OCIOSO, ENTRADA: begin
        // confirmar takes priority over a digit strobe in the same cycle
        if (confirmar) begin
          if (qtd == NUM_D) begin
            estadoProx = VERIFICA;
            idxProx    = '0;
            falhaProx  = 1'b0;
          end else begin
            limpar = 1'b1;
            falhou = 1'b1;
          end
        end else if (digitoAceito) begin
          bufProx[qtd[IDX_W-1:0]] = digito;
          qtdProx    = qtd + 4'd1;
          estadoProx = ENTRADA;
        end
      end

      VERIFICA: begin
        if (!aeqb) falhaProx = 1'b1;
        idxProx = idx + 1'b1;
        if (idx == ULT_IDX) begin
          limpar = 1'b1;
          if (falhaVer || !aeqb) begin
            falhou = 1'b1;
          end else begin
            estadoProx = ABERTO;
            tentProx   = '0;
          end
        end
      end

      ABERTO: begin
        if (confirmar)       estadoProx = OCIOSO;
        else if (modo_troca) estadoProx = TROCA;
      end

      TROCA: begin
        if (confirmar) begin
          limpar = 1'b1;
          if (qtd == NUM_D) begin
            codProx    = bufDig;
            trocaProx  = 1'b1;
            estadoProx = ABERTO;
          end else begin
            // a short new code is rejected but is not a failed attempt
            erroProx = 1'b1;
          end
        end else if (digitoAceito) begin
          bufProx[qtd[IDX_W-1:0]] = digito;
          qtdProx = qtd + 4'd1;
        end
      end

      BLOQUEIO: begin
        if (timer == '0) begin
          estadoProx = OCIOSO;
          tentProx   = '0;
        end else begin
          timerProx = timer - 1'b1;
        end
      end

      default: estadoProx = OCIOSO;
    endcase

    // Shared failure handling for short entries and failed verifications.
    if (falhou) begin
      erroProx = 1'b1;
      if (tent >= MAX_T - 2'd1) begin
        tentProx   = MAX_T;
        estadoProx = BLOQUEIO;
        timerProx  = CARGA_TM;
      end else begin
        tentProx   = tent + 2'd1;
        estadoProx = OCIOSO;
      end
    end

    if (limpar) begin
      qtdProx = '0;
      for (int i = 0; i < NUM_DIGITOS; i++) bufProx[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= OCIOSO;
      qtd      <= '0;
      idx      <= '0;
      falhaVer <= 1'b0;
      tent     <= '0;
      timer    <= '0;
      erroR    <= 1'b0;
      trocaR   <= 1'b0;
      for (int i = 0; i < NUM_DIGITOS; i++) begin
        bufDig[i] <= '0;
        // first-entered digit is the most significant nibble
        codigo[i] <= SENHA_PADRAO[4*(NUM_DIGITOS-1-i) +: 4];
      end
    end else begin
      estado   <= estadoProx;
      qtd      <= qtdProx;
      idx      <= idxProx;
      falhaVer <= falhaProx;
      tent     <= tentProx;
      timer    <= timerProx;
      erroR    <= erroProx;
      trocaR   <= trocaProx;
      for (int i = 0; i < NUM_DIGITOS; i++) begin
        bufDig[i] <= bufProx[i];
        codigo[i] <= codProx[i];
      end
    end
  end

  assign aberto      = (estado == ABERTO) || (estado == TROCA);
  assign bloqueado   = (estado == BLOQUEIO);
  assign erro        = erroR;
  assign troca_ok    = trocaR;
  assign qtd_digitos = qtd;
  assign tentativas  = tent;

endmodule

// File: tb/tb_controle_senha.sv
// Testbench for controle_senha. A transaction-level model predicts the
// observable events (erro / troca_ok pulses, aberto and bloqueado edges)
// together with the cycle at which each must appear; a monitor turns the
// DUT outputs into the same event records and compares them in order.
module tb_controle_senha;

  localparam int N    = 4;
  localparam int MAXT = 3;
  localparam int T    = 16;

  localparam logic [3:0] K_ERRO   = 4'd1;
  localparam logic [3:0] K_TROCA  = 4'd2;
  localparam logic [3:0] K_OPEN   = 4'd3;
  localparam logic [3:0] K_CLOSE  = 4'd4;
  localparam logic [3:0] K_LOCK   = 4'd5;
  localparam logic [3:0] K_UNLOCK = 4'd6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digito = '0;
  logic       digito_valido = 1'b0;
  logic       confirmar = 1'b0;
  logic       modo_troca = 1'b0;
  logic       aberto, bloqueado, erro, troca_ok;
  logic [3:0] qtd_digitos;
  logic [1:0] tentativas;

  controle_senha dut (
    .clk           (clk),
    .reset         (reset),
    .digito        (digito),
    .digito_valido (digito_valido),
    .confirmar     (confirmar),
    .modo_troca    (modo_troca),
    .aberto        (aberto),
    .bloqueado     (bloqueado),
    .erro          (erro),
    .troca_ok      (troca_ok),
    .qtd_digitos   (qtd_digitos),
    .tentativas    (tentativas)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // reference model state
  int m_buf[$];
  int m_code[N];
  int m_tent;
  bit m_open, m_troca;
  int m_lock_end;

  function automatic logic [31:0] ev(input logic [3:0] k, input logic [1:0] t, input int c);
    return {k, t, 26'(c)};
  endfunction

  task automatic chk(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic p_ab = 1'b0, p_bl = 1'b0, p_er = 1'b0, p_tr = 1'b0;

  task automatic check_ev(input logic [31:0] got);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got=%h required=none", got);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        bad++;
        $display("FAIL event got=%h required=%h (kind/tent/cycle)", got, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (erro || troca_ok) begin
        total++;
        if ((erro && troca_ok) || (erro && p_er) || (troca_ok && p_tr)) begin
          bad++;
          $display("FAIL pulse_shape erro=%b troca_ok=%b prev=%b%b required single pulse",
                   erro, troca_ok, p_er, p_tr);
        end
      end
      if (erro)                check_ev(ev(K_ERRO,   tentativas, cyc));
      if (troca_ok)            check_ev(ev(K_TROCA,  tentativas, cyc));
      if (aberto && !p_ab)     check_ev(ev(K_OPEN,   tentativas, cyc));
      if (!aberto && p_ab)     check_ev(ev(K_CLOSE,  tentativas, cyc));
      if (bloqueado && !p_bl)  check_ev(ev(K_LOCK,   tentativas, cyc));
      if (!bloqueado && p_bl)  check_ev(ev(K_UNLOCK, tentativas, cyc));
    end
    p_ab = aberto;
    p_bl = bloqueado;
    p_er = erro;
    p_tr = troca_ok;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic dv, input logic [3:0] d, input logic cf, input logic mt);
    digito_valido = dv;
    digito        = d;
    confirmar     = cf;
    modo_troca    = mt;
    @(posedge clk);
    #1;
    digito_valido = 1'b0;
    confirmar     = 1'b0;
    modo_troca    = 1'b0;
  endtask

  task automatic junk_step();
    step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_code = '{1, 2, 3, 4};
    m_tent = 0;
    m_open = 0;
    m_troca = 0;
    m_lock_end = 0;
  endtask

  task automatic press(input int d);
    step(1'b1, 4'(d), 1'b0, 1'b0);
    if ((!m_open || m_troca) && d <= 9 && m_buf.size() < N) m_buf.push_back(d);
    chk("qtd_digitos", int'(qtd_digitos), m_buf.size());
  endtask

  task automatic press4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic model_fail(input int t);
    m_tent = (m_tent + 1 > MAXT) ? MAXT : m_tent + 1;
    exp_q.push_back(ev(K_ERRO, 2'(m_tent), t));
    if (m_tent == MAXT) begin
      exp_q.push_back(ev(K_LOCK, 2'(MAXT), t));
      exp_q.push_back(ev(K_UNLOCK, 2'd0, t + T));
      m_tent = 0;
      m_lock_end = t + T;
    end
  endtask

  task automatic do_troca();
    step(1'b0, 4'd0, 1'b0, 1'b1);
    if (m_open) m_troca = 1;
  endtask

  task automatic do_confirm(input bit wd, input int d, input bit mt);
    int cc;
    bit match;
    step(wd, 4'(d), 1'b1, mt);
    cc = cyc;
    if (m_troca) begin
      if (m_buf.size() == N) begin
        for (int i = 0; i < N; i++) m_code[i] = m_buf[i];
        exp_q.push_back(ev(K_TROCA, 2'(m_tent), cc));
        m_troca = 0;
      end else begin
        exp_q.push_back(ev(K_ERRO, 2'(m_tent), cc));
      end
      m_buf.delete();
    end else if (m_open) begin
      exp_q.push_back(ev(K_CLOSE, 2'(m_tent), cc));
      m_open = 0;
    end else if (m_buf.size() == N) begin
      match = 1;
      for (int i = 0; i < N; i++) if (m_buf[i] != m_code[i]) match = 0;
      m_buf.delete();
      if (match) begin
        m_tent = 0;
        m_open = 1;
        exp_q.push_back(ev(K_OPEN, 2'd0, cc + N));
      end else begin
        model_fail(cc + N);
      end
      repeat (N) junk_step();
    end else begin
      m_buf.delete();
      model_fail(cc);
    end
    while (cyc + 1 <= m_lock_end) begin
      junk_step();
      chk("qtd_in_lockout", int'(qtd_digitos), 0);
    end
    chk("qtd_after_confirm", int'(qtd_digitos), m_buf.size());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_aberto", int'(aberto), 0);
    chk("rst_bloqueado", int'(bloqueado), 0);
    chk("rst_erro", int'(erro), 0);
    chk("rst_troca_ok", int'(troca_ok), 0);
    chk("rst_qtd", int'(qtd_digitos), 0);
    chk("rst_tent", int'(tentativas), 0);
    reset = 1'b0;
    step(1'b0, 4'd0, 1'b0, 1'b0);

    // default code opens, then close
    press4(1, 2, 3, 4); do_confirm(0, 0, 0);
    chk("open_tent", int'(tentativas), 0);
    do_confirm(0, 0, 0);

    // wrong last digit vs wrong first digit: same latency
    press4(1, 2, 3, 5); do_confirm(0, 0, 0);
    chk("tent_after_1", int'(tentativas), 1);
    press4(9, 2, 3, 4); do_confirm(0, 0, 0);
    press4(1, 2, 3, 4); do_confirm(0, 0, 0);
    do_confirm(0, 0, 0);

    // lockout after three failures, then default code opens
    press4(0, 0, 0, 0); do_confirm(0, 0, 0);
    press4(5, 5, 5, 5); do_confirm(0, 0, 0);
    press4(4, 3, 2, 1); do_confirm(0, 0, 0);
    chk("tent_after_lock", int'(tentativas), 0);
    press4(1, 2, 3, 4); do_confirm(0, 0, 0);

    // code change: short new code rejected, then 7009 stored
    do_troca();
    press(7); press(0); do_confirm(0, 0, 0);
    chk("troca_short_tent", int'(tentativas), 0);
    press4(7, 0, 0, 9); do_confirm(0, 0, 0);
    do_confirm(0, 0, 1);             // confirmar wins over modo_troca
    press4(1, 2, 3, 4); do_confirm(0, 0, 0);
    press4(7, 0, 0, 9); do_confirm(0, 0, 0);
    do_confirm(0, 0, 0);

    // entry edge cases
    press(10);
    press4(7, 0, 0, 9); press(3);    // fifth digit dropped
    do_confirm(1, 5, 0);             // digit with confirmar dropped, opens
    do_confirm(0, 0, 0);
    press(1); press(2); do_confirm(0, 0, 0);
    chk("short_tent", int'(tentativas), 1);
    press(7); press(0); press(0); do_confirm(1, 9, 0);  // still short

    // reset in the middle of verification restores the default code
    press4(7, 0, 0, 9);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_aberto", int'(aberto), 0);
    chk("mid_rst_bloqueado", int'(bloqueado), 0);
    chk("mid_rst_erro", int'(erro), 0);
    chk("mid_rst_qtd", int'(qtd_digitos), 0);
    chk("mid_rst_tent", int'(tentativas), 0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    press4(7, 0, 0, 9); do_confirm(0, 0, 0);
    press4(1, 2, 3, 4); do_confirm(0, 0, 0);
    do_confirm(0, 0, 0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if (m_open && !m_troca) begin
        case ($urandom_range(0, 2))
          0: do_confirm(0, 0, $urandom_range(0, 1));
          1: do_troca();
          default: press($urandom_range(0, 15));
        endcase
      end else if (m_troca) begin
        int k = $urandom_range(0, N + 1);
        for (int i = 0; i < k; i++) press($urandom_range(0, 11));
        do_confirm($urandom_range(0, 1), $urandom_range(0, 15), 0);
      end else begin
        bit good = $urandom_range(0, 1);
        int len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, N) : N;
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 4) == 0) press($urandom_range(10, 15));
          press(good ? m_code[i] : $urandom_range(0, 9));
        end
        if ($urandom_range(0, 3) == 0) press($urandom_range(0, 9));
        do_confirm($urandom_range(0, 1), $urandom_range(0, 15), 0);
      end
    end

    // drain: every predicted event must have been observed
    for (int w = 0; w < 40 && exp_q.size() > 0; w++) step(1'b0, 4'd0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL missing_event got=none required=%h", exp_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
